// File: rtl/axist_prbs_gen.sv
`default_nettype none
// ============================================================================
// Module   : axist_prbs_gen
// Brief    : Multi-lane LFSR pattern source with an AXI-ST valid/ready output,
//            programmable run length, abort and lane-0 period-wrap flag.
// Revision : 1.0 - initial release
// ============================================================================
module axist_prbs_gen #(
    parameter int                LANES  = 2,
    parameter int                LFSR_W = 40,
    parameter logic [LFSR_W-1:0] TAPS   = 40'hA0_0014_0000,
    parameter int                STEP   = 1,
    parameter int                CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [LANES*LFSR_W-1:0]   seed_in,
    input  logic [CNT_W-1:0]          beat_count,
    output logic [LANES*LFSR_W-1:0]   dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      wrapped,
    output logic [CNT_W-1:0]          beats_sent
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [LFSR_W-1:0] lane_q    [LANES];
    logic [LFSR_W-1:0] seed_q    [LANES];
    logic [LFSR_W-1:0] lane_d    [LANES];
    logic [LFSR_W-1:0] w_seed_ld [LANES];
    logic [CNT_W-1:0]  beats_q;
    logic [CNT_W-1:0]  limit_q;
    logic              wrapped_q;
    logic              w_hs;
    logic              w_last;

    // STEP shifts unrolled into one combinational advance per accepted beat
    function automatic logic [LFSR_W-1:0] lfsr_adv(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] v;
        v = s;
        for (int k = 0; k < STEP; k++) begin
            v = {v[LFSR_W-2:0], ^(v & TAPS)};
        end
        return v;
    endfunction

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_seed_ld[i] = (seed_in[i*LFSR_W +: LFSR_W] == '0) ? LFSR_W'(1)
                                                                   : seed_in[i*LFSR_W +: LFSR_W];
        assign dout[i*LFSR_W +: LFSR_W] = lane_q[i];
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_d[i] = lfsr_adv(lane_q[i]);
        end
    end

    assign w_hs   = (state_q == S_RUN) && dout_ready;
    // Limited runs never saturate, so beats_q + 1 cannot wrap here
    assign w_last = (limit_q != '0) && ((beats_q + CNT_W'(1)) == limit_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            beats_q   <= '0;
            limit_q   <= '0;
            wrapped_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= LFSR_W'(1);
                seed_q[i] <= LFSR_W'(1);
            end
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        lane_q    <= w_seed_ld;
                        seed_q    <= w_seed_ld;
                        limit_q   <= beat_count;
                        beats_q   <= '0;
                        wrapped_q <= 1'b0;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        lane_q <= lane_d;
                        if (beats_q != '1) begin
                            beats_q <= beats_q + CNT_W'(1);
                        end
                        if (lane_d[0] == seed_q[0]) begin
                            wrapped_q <= 1'b1;
                        end
                    end
                    // A final beat that coincides with stop still counts as a completed run
                    if (w_hs && w_last) begin
                        state_q <= S_DONE;
                    end else if (stop) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout_valid = (state_q == S_RUN);
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign wrapped    = wrapped_q;
    assign beats_sent = beats_q;

endmodule
`default_nettype wire

// File: tb/tb_axist_prbs_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axist_prbs_gen
// Brief    : Scoreboard bench for axist_prbs_gen (2x40-bit and 1x4-bit builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axist_prbs_gen;

    localparam logic [39:0] ATAPS = 40'hA0_0014_0000;
    localparam logic [3:0]  BTAPS = 4'b1100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_start = 1'b0, a_stop = 1'b0, a_ready = 1'b0;
    logic [79:0] a_seed = '0;
    logic [15:0] a_cnt = '0;
    logic [79:0] a_dout;
    logic        a_valid, a_busy, a_done, a_wrapped;
    logic [15:0] a_beats;

    logic        b_start = 1'b0, b_stop = 1'b0, b_ready = 1'b0;
    logic [3:0]  b_seed = '0;
    logic [4:0]  b_cnt = '0;
    logic [3:0]  b_dout;
    logic        b_valid, b_busy, b_done, b_wrapped;
    logic [4:0]  b_beats;

    axist_prbs_gen #(.LANES(2), .LFSR_W(40), .TAPS(ATAPS), .STEP(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .stop(a_stop), .seed_in(a_seed),
        .beat_count(a_cnt), .dout(a_dout), .dout_valid(a_valid), .dout_ready(a_ready),
        .busy(a_busy), .done(a_done), .wrapped(a_wrapped), .beats_sent(a_beats));

    axist_prbs_gen #(.LANES(1), .LFSR_W(4), .TAPS(BTAPS), .STEP(1), .CNT_W(5)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .seed_in(b_seed),
        .beat_count(b_cnt), .dout(b_dout), .dout_valid(b_valid), .dout_ready(b_ready),
        .busy(b_busy), .done(b_done), .wrapped(b_wrapped), .beats_sent(b_beats));

    int checks = 0;
    int errors = 0;
    logic [79:0] qa[$];
    logic [3:0]  qb[$];
    int hs_a = 0;
    int hs_b = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: one shift = multiply by two mod 2^w, plus parity of the tapped bits
    function automatic logic [63:0] ref_next(input logic [63:0] s, input int w, input logic [63:0] taps);
        logic [63:0] mask;
        logic        fb;
        mask = (64'd1 << w) - 64'd1;
        fb   = ^(s & taps);
        return ((s * 64'd2) + {63'd0, fb}) & mask;
    endfunction

    function automatic logic [39:0] nz40(input logic [39:0] s);
        return (s == 40'd0) ? 40'd1 : s;
    endfunction

    logic        a_hold_pend = 1'b0;
    logic [79:0] a_held = '0;

    always @(negedge clk) begin
        if (rst) begin
            a_hold_pend = 1'b0;
        end else begin
            if (a_hold_pend) begin
                chk("a_hold_dout", a_dout, a_held);
                chk("a_hold_valid", {79'd0, a_valid}, 80'd1);
            end
            a_hold_pend = a_valid && !a_ready;
            a_held      = a_dout;
            if (a_valid && a_ready) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_beat: got unexpected beat %0h expected none", a_dout);
                end else begin
                    chk("a_beat", a_dout, qa.pop_front());
                end
                hs_a++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_valid && b_ready) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_beat: got unexpected beat %0h expected none", b_dout);
            end else begin
                chk("b_beat", {76'd0, b_dout}, {76'd0, qb.pop_front()});
            end
            hs_b++;
        end
    end

    // mode 0: ready always high (seed lane0 = 1 only), 1: random ready, 2: 3-cycle stall after beat 2 (seed lane0 = 1 only)
    task automatic run_a(input logic [79:0] seed, input logic [15:0] cnt, input int mode,
                         input int nstop, input logic stop_with_start);
        logic [79:0] st;
        int n, base, cyc, d, stalled;
        st = {nz40(seed[79:40]), nz40(seed[39:0])};
        n  = (cnt != 16'd0) ? int'(cnt) : nstop;
        for (int k = 0; k < n; k++) begin
            qa.push_back(st);
            st = {ref_next({24'd0, st[79:40]}, 40, {24'd0, ATAPS})[39:0],
                  ref_next({24'd0, st[39:0]},  40, {24'd0, ATAPS})[39:0]};
        end
        base    = hs_a;
        stalled = 0;
        a_seed  = seed;
        a_cnt   = cnt;
        a_start = 1'b1;
        a_stop  = stop_with_start;
        a_ready = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_stop  = 1'b0;
        a_seed  = {$urandom, $urandom, $urandom};
        a_cnt   = 16'($urandom);
        chk("a_busy_start", {79'd0, a_busy}, 80'd1);
        chk("a_valid_start", {79'd0, a_valid}, 80'd1);
        chk("a_beats_start", {64'd0, a_beats}, 80'd0);
        chk("a_wrapped_start", {79'd0, a_wrapped}, 80'd0);
        cyc = 0;
        while (a_valid && cyc < 2000) begin
            d = hs_a - base;
            a_start = (mode == 1 && cyc == 3);
            if (cnt == 16'd0 && d == nstop - 1) begin
                a_ready = 1'b1;
                a_stop  = 1'b1;
            end else if (mode == 1) begin
                a_ready = 1'($urandom_range(0, 1));
            end else if (mode == 2 && d == 2 && stalled < 3) begin
                a_ready = 1'b0;
                stalled++;
                chk("a_stall_dout", {40'd0, a_dout[39:0]}, 80'h4);
            end else begin
                a_ready = 1'b1;
            end
            if (mode == 0 && d == 18) chk("a_beat18", {40'd0, a_dout[39:0]}, 80'h40000);
            if (mode == 0 && d == 19) chk("a_beat19", {40'd0, a_dout[39:0]}, 80'h80001);
            @(posedge clk); #1;
            a_stop  = 1'b0;
            a_start = 1'b0;
            cyc++;
        end
        if (cyc >= 2000) begin
            checks++;
            errors++;
            $display("FAIL a_timeout: got %0d beats expected %0d", hs_a - base, n);
        end
        a_ready = 1'b0;
        chk("a_beats_end", {64'd0, a_beats}, 80'(n));
        chk("a_valid_end", {79'd0, a_valid}, 80'd0);
        chk("a_busy_end", {79'd0, a_busy}, 80'd0);
        chk("a_done_end", {79'd0, a_done}, {79'd0, cnt != 16'd0});
        chk("a_wrapped_end", {79'd0, a_wrapped}, 80'd0);
        chk("a_queue_left", 80'(qa.size()), 80'd0);
        qa.delete();
    endtask

    task automatic run_b(input logic [3:0] seed, input logic [4:0] cnt, input int mode, input int nstop);
        logic [3:0] st, s0, s;
        int n, base, cyc, d, p;
        s0 = (seed == 4'd0) ? 4'd1 : seed;
        st = s0;
        n  = (cnt != 5'd0) ? int'(cnt) : nstop;
        for (int k = 0; k < n; k++) begin
            qb.push_back(st);
            st = ref_next({60'd0, st}, 4, {60'd0, BTAPS})[3:0];
        end
        p = 0;
        s = s0;
        do begin
            s = ref_next({60'd0, s}, 4, {60'd0, BTAPS})[3:0];
            p++;
        end while (s != s0 && p < 100);
        base    = hs_b;
        b_seed  = seed;
        b_cnt   = cnt;
        b_start = 1'b1;
        b_ready = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_seed  = 4'($urandom);
        cyc = 0;
        while (b_valid && cyc < 2000) begin
            d = hs_b - base;
            chk("b_wrapped_run", {79'd0, b_wrapped}, {79'd0, d >= p});
            chk("b_beats_run", {75'd0, b_beats}, 80'((d > 31) ? 31 : d));
            if (cnt == 5'd0 && d == nstop - 1) begin
                b_ready = 1'b1;
                b_stop  = 1'b1;
            end else begin
                b_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(posedge clk); #1;
            b_stop = 1'b0;
            cyc++;
        end
        if (cyc >= 2000) begin
            checks++;
            errors++;
            $display("FAIL b_timeout: got %0d beats expected %0d", hs_b - base, n);
        end
        b_ready = 1'b0;
        chk("b_beats_end", {75'd0, b_beats}, 80'((n > 31) ? 31 : n));
        chk("b_wrapped_end", {79'd0, b_wrapped}, {79'd0, n >= p});
        chk("b_done_end", {79'd0, b_done}, {79'd0, cnt != 5'd0});
        chk("b_queue_left", 80'(qb.size()), 80'd0);
        qb.delete();
    endtask

    task automatic chk_reset_vals();
        chk("rst_a_dout", a_dout, {40'd1, 40'd1});
        chk("rst_a_flags", {76'd0, a_valid, a_busy, a_done, a_wrapped}, 80'd0);
        chk("rst_a_beats", {64'd0, a_beats}, 80'd0);
        chk("rst_b_dout", {76'd0, b_dout}, 80'd1);
        chk("rst_b_flags", {76'd0, b_valid, b_busy, b_done, b_wrapped}, 80'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rst = 1'b0;
        @(posedge clk); #1;

        run_a({40'h0, 40'h1}, 16'd0, 0, 20, 1'b0);
        run_a({40'h0, 40'h1}, 16'd5, 0, 0, 1'b0);
        a_stop = 1'b1;
        @(posedge clk); #1;
        a_stop = 1'b0;
        @(posedge clk); #1;
        chk("a_done_held", {79'd0, a_done}, 80'd1);
        chk("a_valid_done", {79'd0, a_valid}, 80'd0);

        run_a({40'h0, 40'h1}, 16'd6, 2, 0, 1'b0);
        run_a({40'h0, 40'h3}, 16'd0, 1, 12, 1'b1);
        run_a({$urandom, $urandom, $urandom}, 16'd0, 1, 3, 1'b0);
        run_a({$urandom, $urandom, $urandom}, 16'd1, 1, 0, 1'b0);
        run_a({$urandom, $urandom, $urandom}, 16'd0, 1, 1, 1'b0);
        run_a(80'd0, 16'd4, 1, 0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 0)
                run_a({$urandom, $urandom, $urandom}, 16'($urandom_range(1, 25)), 1, 0, 1'b0);
            else
                run_a({$urandom, $urandom, $urandom}, 16'd0, 1, $urandom_range(1, 25), 1'b0);
        end

        // Reset in the middle of an unlimited run
        begin
            logic [79:0] st;
            st = {40'h5, 40'h9};
            for (int k = 0; k < 10; k++) begin
                qa.push_back(st);
                st = {ref_next({24'd0, st[79:40]}, 40, {24'd0, ATAPS})[39:0],
                      ref_next({24'd0, st[39:0]},  40, {24'd0, ATAPS})[39:0]};
            end
            a_seed = {40'h5, 40'h9}; a_cnt = 16'd0; a_start = 1'b1; a_ready = 1'b1;
            @(posedge clk); #1;
            a_start = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk); #1;
            chk_reset_vals();
            qa.delete();
            a_ready = 1'b0;
            rst = 1'b0;
            @(posedge clk); #1;
        end

        run_b(4'h1, 5'd0, 0, 40);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("b_wrapped_rst", {79'd0, b_wrapped}, 80'd0);
        chk("b_beats_rst", {75'd0, b_beats}, 80'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_b(4'($urandom_range(1, 15)), 5'd0, 1, 20);
        run_b(4'h0, 5'd7, 1, 0);
        run_b(4'($urandom), 5'd0, 1, 14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
